// File: rtl/controller_if.sv
// Decode-stage bus: instruction word and stall in, registered decode controls out.
// master = instruction fetch side, slave = controller.
interface controller_if;
    logic        stall;
    logic [31:0] in32;
    logic [5:0]  rs;
    logic [5:0]  rd;
    logic [5:0]  rt;
    logic [14:0] imm;
    logic [3:0]  ALUopsel;
    logic        WE1;
    logic        WE2;
    logic        MUXsel1;
    logic        MUXsel2;
    logic        illegal;

    modport master (
        output stall, in32,
        input  rs, rd, rt, imm, ALUopsel, WE1, WE2, MUXsel1, MUXsel2, illegal
    );

    modport slave (
        input  stall, in32,
        output rs, rd, rt, imm, ALUopsel, WE1, WE2, MUXsel1, MUXsel2, illegal
    );
endinterface

// File: rtl/controller.sv
// Purpose: instruction decode into register specifiers, immediate and datapath controls.
// Latency: 1 cycle (all outputs registered). Backpressure: stall holds every output register.
// Option: CONTROLLER_ILLEGAL_TRAP_EN flags opcode 1110 as illegal; otherwise it decodes as NOP.
module controller (
    input  logic         clk,
    input  logic         rst,
    controller_if.slave  cif
);
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1101;
    localparam logic [3:0] OP_RSVD  = 4'b1110;

    logic       i_form;
    logic [3:0] op;
    logic [3:0] alu_nxt;
    logic       we1_nxt;
    logic       we2_nxt;
    logic       mux2_nxt;
    logic       ill_nxt;

    assign i_form = cif.in32[31];
    assign op     = cif.in32[30:27];

    // Plain ALU ops pass the opcode straight through as the ALU select.
    always_comb begin
        alu_nxt  = op;
        we1_nxt  = 1'b1;
        we2_nxt  = 1'b0;
        mux2_nxt = 1'b0;
        ill_nxt  = 1'b0;
        case (op)
            OP_NOP: begin
                alu_nxt = 4'b0000;
                we1_nxt = 1'b0;
            end
            OP_LOAD: begin
                alu_nxt  = 4'b0000;
                mux2_nxt = 1'b1;
            end
            OP_STORE: begin
                alu_nxt  = 4'b0000;
                we1_nxt  = 1'b0;
                we2_nxt  = 1'b1;
                mux2_nxt = 1'b1;
            end
            OP_RSVD: begin
                alu_nxt = 4'b0000;
                we1_nxt = 1'b0;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
                ill_nxt = 1'b1;
`else
                ill_nxt = 1'b0;
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cif.rs       <= '0;
            cif.rd       <= '0;
            cif.rt       <= '0;
            cif.imm      <= '0;
            cif.ALUopsel <= '0;
            cif.WE1      <= 1'b0;
            cif.WE2      <= 1'b0;
            cif.MUXsel1  <= 1'b0;
            cif.MUXsel2  <= 1'b0;
            cif.illegal  <= 1'b0;
        end else if (!cif.stall) begin
            cif.rd       <= cif.in32[26:21];
            cif.rs       <= cif.in32[20:15];
            cif.rt       <= i_form ? 6'd0 : cif.in32[14:9];
            cif.imm      <= i_form ? cif.in32[14:0] : 15'd0;
            cif.ALUopsel <= alu_nxt;
            cif.WE1      <= we1_nxt;
            cif.WE2      <= we2_nxt;
            cif.MUXsel1  <= i_form;
            cif.MUXsel2  <= mux2_nxt;
            cif.illegal  <= ill_nxt;
        end
    end
endmodule

// File: tb/tb_controller.sv
// Bench for controller: directed steps from the decode rules, then random words,
// stalls and resets checked against an instruction-level reference model.
module tb_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    controller_if bus ();

    controller dut (
        .clk (clk),
        .rst (rst),
        .cif (bus)
    );

    typedef struct {
        int unsigned rs, rd, rt, imm, alu;
        int unsigned we1, we2, m1, m2, ill;
    } exp_t;

    exp_t exp_q;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference decode written as field arithmetic over the word.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        r;
        int unsigned word;
        int unsigned op;
        int unsigned iform;
        bit          trap;
        word    = w;
        iform   = word / 32'h8000_0000;
        op      = (word / (1 << 27)) % 16;
        r.rd    = (word / (1 << 21)) % 64;
        r.rs    = (word / (1 << 15)) % 64;
        r.rt    = iform ? 0 : (word / (1 << 9)) % 64;
        r.imm   = iform ? word % 32768 : 0;
        r.m1    = iform;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        r.ill = 0;
        if (op == 12) begin
            r.alu = 0; r.we1 = 1; r.we2 = 0; r.m2 = 1;
        end else if (op == 13) begin
            r.alu = 0; r.we1 = 0; r.we2 = 1; r.m2 = 1;
        end else if (op == 10 || op == 14) begin
            r.alu = 0; r.we1 = 0; r.we2 = 0; r.m2 = 0;
            if (op == 14 && trap) r.ill = 1;
        end else begin
            r.alu = op; r.we1 = 1; r.we2 = 0; r.m2 = 0;
        end
        return r;
    endfunction

    function automatic exp_t zero_exp();
        exp_t r;
        r = '{default: 0};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".rs"},       32'(bus.rs),       exp_q.rs);
        check({ctx, ".rd"},       32'(bus.rd),       exp_q.rd);
        check({ctx, ".rt"},       32'(bus.rt),       exp_q.rt);
        check({ctx, ".imm"},      32'(bus.imm),      exp_q.imm);
        check({ctx, ".ALUopsel"}, 32'(bus.ALUopsel), exp_q.alu);
        check({ctx, ".WE1"},      32'(bus.WE1),      exp_q.we1);
        check({ctx, ".WE2"},      32'(bus.WE2),      exp_q.we2);
        check({ctx, ".MUXsel1"},  32'(bus.MUXsel1),  exp_q.m1);
        check({ctx, ".MUXsel2"},  32'(bus.MUXsel2),  exp_q.m2);
        check({ctx, ".illegal"},  32'(bus.illegal),  exp_q.ill);
        check({ctx, ".we_excl"},  32'(bus.WE1 & bus.WE2), 32'd0);
    endtask

    // Drive inputs, take one rising edge, update the model, then compare.
    task automatic step(input logic r, input logic s, input logic [31:0] w, input string ctx);
        rst       = r;
        bus.stall = s;
        bus.in32  = w;
        @(posedge clk);
        if (r)       exp_q = zero_exp();
        else if (!s) exp_q = ref_decode(w);
        #1;
        check_all(ctx);
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.in32  = 32'hFFFF_FFFF;
        exp_q     = zero_exp();
        @(negedge clk);

        step(1'b1, 1'b0, 32'hFFFF_FFFF, "rst1");
        step(1'b1, 1'b1, 32'hFFFF_FFFF, "rst2");
        step(1'b0, 1'b0, 32'hFFFF_FFFF, "post_rst");

        step(1'b0, 1'b0, 32'hBD54_7E00, "imm_srl");
        check("imm_srl.rd_const",  32'(bus.rd),       32'd42);
        check("imm_srl.rs_const",  32'(bus.rs),       32'd40);
        check("imm_srl.imm_const", 32'(bus.imm),      32'h7E00);
        check("imm_srl.alu_const", 32'(bus.ALUopsel), 32'd7);

        step(1'b0, 1'b0, 32'h7AA8_7E00, "reg_passb");
        check("reg_passb.rd_const", 32'(bus.rd), 32'd21);
        check("reg_passb.rs_const", 32'(bus.rs), 32'd16);
        check("reg_passb.rt_const", 32'(bus.rt), 32'd63);

        step(1'b0, 1'b0, 32'hE861_0010, "store");
        check("store.we2_const", 32'(bus.WE2), 32'd1);
        check("store.rd_const",  32'(bus.rd),  32'd3);
        step(1'b0, 1'b0, 32'hE0A1_0000, "load");
        check("load.mux2_const", 32'(bus.MUXsel2), 32'd1);
        check("load.rd_const",   32'(bus.rd),      32'd5);

        step(1'b0, 1'b0, 32'hBD54_7E00, "stall_pre");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'hE861_0010, "stall_hold");
        check("stall_hold.alu_const", 32'(bus.ALUopsel), 32'd7);
        step(1'b0, 1'b0, 32'hE861_0010, "stall_release");
        check("stall_release.we2_const", 32'(bus.WE2), 32'd1);

        step(1'b0, 1'b0, 32'h7000_0000, "reserved");
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        check("reserved.ill_const", 32'(bus.illegal), 32'd1);
`else
        check("reserved.ill_const", 32'(bus.illegal), 32'd0);
`endif
        step(1'b0, 1'b0, 32'h5000_0000, "nop");
        check("nop.we1_const", 32'(bus.WE1), 32'd0);

        step(1'b1, 1'b0, 32'hBD54_7E00, "mid_rst");
        step(1'b0, 1'b0, 32'hBD54_7E00, "after_mid_rst");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            logic        s;
            logic        r;
            w = $urandom;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 24) == 0);
            step(r, s, w, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
